updi_txn_engine: RTL and testbench
==================================

Name: updi_txn_engine

Overview:
- Parametrised successor to the UPDI interface bridge: runs one complete UPDI transaction per command.
- Sequence: SYNCH byte, opcode, N payload bytes, then M response bytes.
- Handles the half-duplex single-wire echo, per-byte ACK checking and per-byte timeouts; ends with a status code.
- Sits between the command layer and the UART TX/RX FIFOs, in the UPDI top level.

Parameters:
LEN_W, 8, width of payload/response byte counts (max 2^LEN_W-1 bytes each)
TIMEOUT_CLKS, 100, clocks allowed waiting for any single RX byte (echo, ACK or response)
SYNC_BYTE, 8'h55, UPDI SYNCH character sent before every opcode
ACK_BYTE, 8'h40, expected ACK value
ECHO_DISCARD, 1, 1 = every transmitted byte is read back from RX and discarded before continuing

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low
cmd_valid  in  1  command offered
cmd_ready  out  1  engine idle, command accepted on valid&ready
cmd_opcode  in  8  encoded UPDI opcode
cmd_tx_len  in  LEN_W  payload bytes to send after opcode
cmd_rx_len  in  LEN_W  response bytes to collect
cmd_ack_mode  in  1  expect ACK after each payload byte
pl_data  in  8  payload stream byte
pl_valid  in  1  payload byte available
pl_ready  out  1  payload byte consumed
rx_data  out  8  response byte to output FIFO
rx_wr_en  out  1  response byte write strobe
rx_full  in  1  output FIFO full
uart_tx_fifo_data  out  8  byte to UART TX FIFO
uart_tx_fifo_wr_en  out  1  TX write strobe
uart_tx_fifo_full  in  1  TX FIFO full
uart_rx_fifo_data  in  8  UART RX FIFO head (first-word-fall-through)
uart_rx_fifo_rd_en  out  1  RX pop
uart_rx_fifo_empty  in  1  RX FIFO empty
done  out  1  one-cycle pulse at transaction end
status  out  2  result, valid with done and held until next command: 0 OK, 1 TIMEOUT, 2 NACK, 3 ECHO_MISMATCH
break_req  out  1  one-cycle pulse with done when status != OK

Behaviour:
- Reset (rst low, async): state IDLE. All outputs 0 except cmd_ready=1. Counters cleared. A reset mid-transaction abandons it; no done pulse is produced.
- States: IDLE, SYNC, OPC, PAYLOAD, ECHO, ACK, RESP, FINISH.
- IDLE: cmd_ready=1. On valid&ready, latch opcode, both lengths and ack_mode; go to SYNC.
- SYNC / OPC: write SYNC_BYTE / opcode when !uart_tx_fifo_full; one wr_en per byte.
  - ECHO_DISCARD=1: go to ECHO next.
  - ECHO_DISCARD=0: proceed directly.
- PAYLOAD: when pl_valid & !uart_tx_fifo_full, assert pl_ready and uart_tx_fifo_wr_en in the same cycle. Decrement remaining tx count.
- ECHO: when !uart_rx_fifo_empty, pop one byte and discard it. Next state:
  - ACK, if the echoed byte was a payload byte and ack_mode=1;
  - otherwise PAYLOAD while payload remains, else RESP.
- ACK: pop one byte. Equal to ACK_BYTE continues; any other value gives status NACK and goes to FINISH.
- RESP: when !uart_rx_fifo_empty & !rx_full, pop the byte, forward it on rx_data with rx_wr_en, decrement. At count 0 go to FINISH with OK.
- Zero-length cases: cmd_tx_len=0 skips PAYLOAD; cmd_rx_len=0 makes RESP exit immediately.
- Timeout: counter of width $clog2(TIMEOUT_CLKS+1).
  - Cleared on every state entry and every byte transfer.
  - Increments only in ECHO/ACK/RESP while the RX FIFO is empty.
  - Frozen while rx_full stalls RESP.
  - Reaching TIMEOUT_CLKS gives status TIMEOUT, then FINISH.
- TX-side stalls (uart_tx_fifo_full, !pl_valid) never time out.
- FINISH: done=1 for one cycle, plus break_req if error; return to IDLE. cmd_ready is low during FINISH.
- Simultaneous RX byte arrival and timeout expiry: the byte wins.

Optional Feature:
- Macro UPDI_ECHO_CHECK_EN.
- Defined: in ECHO, each popped byte is compared with the last transmitted byte. A mismatch gives status ECHO_MISMATCH (bus collision), then FINISH.
- Undefined: echoes are discarded unchecked; status 3 is never produced.

Decomposition:
- Package updi_txn_pkg holds:
  - status enum (OK/TIMEOUT/NACK/ECHO_MISMATCH);
  - state enum;
  - SYNC_BYTE and ACK_BYTE default constants.
- One natural sub-module, updi_rx_timeout: loadable/clearable timeout counter with expiry flag, reusable by the input handler.

Test Plan:
1. Opcode 8'h80, tx_len=0, rx_len=1, ECHO_DISCARD=1; bench echoes 55,80 then returns 8'h30 → TX sees 55,80; rx_data=30 once; done with status 0, no break_req.
2. Opcode 8'h64, tx_len=2 (11,22), ack_mode=1; bench echoes each byte and returns 40 after each payload byte → TX 55,64,11,22; status 0; pl_ready pulses exactly twice.
3. Same as 2, but the first ACK is 8'h00 → status 2 and break_req after the first payload byte; 22 is never sent.
4. rx_len=2 and only one response byte supplied → done exactly TIMEOUT_CLKS cycles after the last pop; status 1; break_req=1.
5. rx_full held for 500 cycles during RESP → no timeout; bytes are delivered in order once released. With UPDI_ECHO_CHECK_EN, an echo of 8'h54 for 55 gives status 3.
6. Drive rst low mid-PAYLOAD → outputs zero at once, cmd_ready=1, no done. The next command completes normally.

Source files
------------

// File: rtl/updi_txn_pkg.sv
// Shared types and constants for the UPDI transaction engine.
package updi_txn_pkg;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'h55;
    localparam logic [7:0] ACK_BYTE_DEF  = 8'h40;

    typedef enum logic [1:0] {
        ST_OK            = 2'd0,
        ST_TIMEOUT       = 2'd1,
        ST_NACK          = 2'd2,
        ST_ECHO_MISMATCH = 2'd3
    } status_e;

    localparam int unsigned STATE_W = 3;

    localparam logic [STATE_W-1:0] S_IDLE    = 3'd0;
    localparam logic [STATE_W-1:0] S_SYNC    = 3'd1;
    localparam logic [STATE_W-1:0] S_OPC     = 3'd2;
    localparam logic [STATE_W-1:0] S_PAYLOAD = 3'd3;
    localparam logic [STATE_W-1:0] S_ECHO    = 3'd4;
    localparam logic [STATE_W-1:0] S_ACK     = 3'd5;
    localparam logic [STATE_W-1:0] S_RESP    = 3'd6;
    localparam logic [STATE_W-1:0] S_FINISH  = 3'd7;

    // Which kind of byte the pending echo belongs to; selects the state after ECHO.
    typedef enum logic [1:0] {
        EK_SYNC    = 2'd0,
        EK_OPC     = 2'd1,
        EK_PAYLOAD = 2'd2
    } echo_kind_e;

    function automatic logic is_rx_wait(input logic [STATE_W-1:0] st);
        return (st == S_ECHO) || (st == S_ACK) || (st == S_RESP);
    endfunction

endpackage

// File: rtl/updi_rx_timeout.sv
// Per-byte RX timeout counter: clear/load/increment, saturating at LIMIT.
// expire_c flags the increment that brings the count up to LIMIT.
module updi_rx_timeout #(
    parameter  int unsigned LIMIT = 100,
    localparam int unsigned CW    = $clog2(LIMIT + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          inc,
    output logic          expire_c
);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (inc && (cnt != CW'(LIMIT))) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign expire_c = inc && (cnt >= CW'(LIMIT - 1));

endmodule

// File: rtl/updi_txn_engine.sv
// UPDI transaction engine: SYNCH, opcode, payload and response with echo/ACK/timeout handling.
// Optional echo comparison against the transmitted byte is enabled by UPDI_ECHO_CHECK_EN.
module updi_txn_engine
    import updi_txn_pkg::*;
#(
    parameter int unsigned LEN_W        = 8,
    parameter int unsigned TIMEOUT_CLKS = 100,
    parameter logic [7:0]  SYNC_BYTE    = SYNC_BYTE_DEF,
    parameter logic [7:0]  ACK_BYTE     = ACK_BYTE_DEF,
    parameter bit          ECHO_DISCARD = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [7:0]       cmd_opcode,
    input  logic [LEN_W-1:0] cmd_tx_len,
    input  logic [LEN_W-1:0] cmd_rx_len,
    input  logic             cmd_ack_mode,
    input  logic [7:0]       pl_data,
    input  logic             pl_valid,
    output logic             pl_ready,
    output logic [7:0]       rx_data,
    output logic             rx_wr_en,
    input  logic             rx_full,
    output logic [7:0]       uart_tx_fifo_data,
    output logic             uart_tx_fifo_wr_en,
    input  logic             uart_tx_fifo_full,
    input  logic [7:0]       uart_rx_fifo_data,
    output logic             uart_rx_fifo_rd_en,
    input  logic             uart_rx_fifo_empty,
    output logic             done,
    output logic [1:0]       status,
    output logic             break_req
);

    logic [STATE_W-1:0] state, state_d;
    logic [7:0]         opcode_q, opcode_d;
    logic [LEN_W-1:0]   tx_rem, tx_rem_d;
    logic [LEN_W-1:0]   rx_rem, rx_rem_d;
    logic               ack_mode, ack_mode_d;
    echo_kind_e         echo_kind, echo_kind_d;
    status_e            status_q, status_d;
`ifdef UPDI_ECHO_CHECK_EN
    logic [7:0]         last_tx, last_tx_d;
`endif

    logic               cmd_ready_d, pl_ready_d, rx_wr_en_d, tx_wr_en_d, rd_en_d;
    logic               done_d, break_d;
    logic [7:0]         rx_data_d, tx_data_d;

    logic               busy_c, fin_c;
    status_e            fin_status_c;
    logic               tmr_clr_c, tmr_inc_c, tmr_expire_c;

    // Strobes are registered, so FIFO flags lag one cycle behind a transfer;
    // no new decision is taken while a strobe is on the wire.
    assign busy_c = uart_tx_fifo_wr_en | uart_rx_fifo_rd_en;

    // Pop-strobe cycles count as waiting so the budget runs from the pop itself.
    assign tmr_inc_c = is_rx_wait(state) && !((state == S_RESP) && rx_full)
                       && (busy_c || uart_rx_fifo_empty);

    updi_rx_timeout #(
        .LIMIT(TIMEOUT_CLKS)
    ) u_timeout (
        .clk      (clk),
        .rst      (rst),
        .clr      (tmr_clr_c),
        .load     (1'b0),
        .load_val ('0),
        .inc      (tmr_inc_c),
        .expire_c (tmr_expire_c)
    );

    // Next-state and next-output logic.
    always_comb begin
        state_d      = state;
        opcode_d     = opcode_q;
        tx_rem_d     = tx_rem;
        rx_rem_d     = rx_rem;
        ack_mode_d   = ack_mode;
        echo_kind_d  = echo_kind;
        status_d     = status_q;
`ifdef UPDI_ECHO_CHECK_EN
        last_tx_d    = last_tx;
`endif
        pl_ready_d   = 1'b0;
        rx_wr_en_d   = 1'b0;
        tx_wr_en_d   = 1'b0;
        rd_en_d      = 1'b0;
        done_d       = 1'b0;
        break_d      = 1'b0;
        rx_data_d    = rx_data;
        tx_data_d    = uart_tx_fifo_data;
        fin_c        = 1'b0;
        fin_status_c = ST_OK;

        case (state)
            S_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    opcode_d   = cmd_opcode;
                    tx_rem_d   = cmd_tx_len;
                    rx_rem_d   = cmd_rx_len;
                    ack_mode_d = cmd_ack_mode;
                    status_d   = ST_OK;
                    state_d    = S_SYNC;
                end
            end

            S_SYNC: begin
                if (!busy_c && !uart_tx_fifo_full) begin
                    tx_wr_en_d  = 1'b1;
                    tx_data_d   = SYNC_BYTE;
                    echo_kind_d = EK_SYNC;
`ifdef UPDI_ECHO_CHECK_EN
                    last_tx_d   = SYNC_BYTE;
`endif
                    state_d     = ECHO_DISCARD ? S_ECHO : S_OPC;
                end
            end

            S_OPC: begin
                if (!busy_c && !uart_tx_fifo_full) begin
                    tx_wr_en_d  = 1'b1;
                    tx_data_d   = opcode_q;
                    echo_kind_d = EK_OPC;
`ifdef UPDI_ECHO_CHECK_EN
                    last_tx_d   = opcode_q;
`endif
                    if (ECHO_DISCARD) begin
                        state_d = S_ECHO;
                    end else begin
                        state_d = (tx_rem != '0) ? S_PAYLOAD : S_RESP;
                    end
                end
            end

            S_PAYLOAD: begin
                if (!busy_c && pl_valid && !uart_tx_fifo_full) begin
                    pl_ready_d  = 1'b1;
                    tx_wr_en_d  = 1'b1;
                    tx_data_d   = pl_data;
                    tx_rem_d    = tx_rem - LEN_W'(1);
                    echo_kind_d = EK_PAYLOAD;
`ifdef UPDI_ECHO_CHECK_EN
                    last_tx_d   = pl_data;
`endif
                    if (ECHO_DISCARD) begin
                        state_d = S_ECHO;
                    end else if (ack_mode) begin
                        state_d = S_ACK;
                    end else begin
                        state_d = (tx_rem_d != '0) ? S_PAYLOAD : S_RESP;
                    end
                end
            end

            S_ECHO: begin
                if (!busy_c) begin
                    if (!uart_rx_fifo_empty) begin
                        rd_en_d = 1'b1;
`ifdef UPDI_ECHO_CHECK_EN
                        if (uart_rx_fifo_data != last_tx) begin
                            fin_c        = 1'b1;
                            fin_status_c = ST_ECHO_MISMATCH;
                        end else
`endif
                        if (echo_kind == EK_SYNC) begin
                            state_d = S_OPC;
                        end else if ((echo_kind == EK_PAYLOAD) && ack_mode) begin
                            state_d = S_ACK;
                        end else begin
                            state_d = (tx_rem != '0) ? S_PAYLOAD : S_RESP;
                        end
                    end else if (tmr_expire_c) begin
                        fin_c        = 1'b1;
                        fin_status_c = ST_TIMEOUT;
                    end
                end
            end

            S_ACK: begin
                if (!busy_c) begin
                    if (!uart_rx_fifo_empty) begin
                        rd_en_d = 1'b1;
                        if (uart_rx_fifo_data == ACK_BYTE) begin
                            state_d = (tx_rem != '0) ? S_PAYLOAD : S_RESP;
                        end else begin
                            fin_c        = 1'b1;
                            fin_status_c = ST_NACK;
                        end
                    end else if (tmr_expire_c) begin
                        fin_c        = 1'b1;
                        fin_status_c = ST_TIMEOUT;
                    end
                end
            end

            S_RESP: begin
                if (rx_rem == '0) begin
                    fin_c = 1'b1;
                end else if (!busy_c) begin
                    if (!uart_rx_fifo_empty && !rx_full) begin
                        rd_en_d    = 1'b1;
                        rx_wr_en_d = 1'b1;
                        rx_data_d  = uart_rx_fifo_data;
                        rx_rem_d   = rx_rem - LEN_W'(1);
                    end else if (uart_rx_fifo_empty && tmr_expire_c) begin
                        fin_c        = 1'b1;
                        fin_status_c = ST_TIMEOUT;
                    end
                end
            end

            S_FINISH: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (fin_c) begin
            state_d  = S_FINISH;
            done_d   = 1'b1;
            status_d = fin_status_c;
            break_d  = (fin_status_c != ST_OK);
        end

        cmd_ready_d = (state_d == S_IDLE);
        tmr_clr_c   = (state_d != state) || tx_wr_en_d || rd_en_d;
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state              <= S_IDLE;
            opcode_q           <= '0;
            tx_rem             <= '0;
            rx_rem             <= '0;
            ack_mode           <= 1'b0;
            echo_kind          <= EK_SYNC;
            status_q           <= ST_OK;
`ifdef UPDI_ECHO_CHECK_EN
            last_tx            <= '0;
`endif
            cmd_ready          <= 1'b1;
            pl_ready           <= 1'b0;
            rx_data            <= '0;
            rx_wr_en           <= 1'b0;
            uart_tx_fifo_data  <= '0;
            uart_tx_fifo_wr_en <= 1'b0;
            uart_rx_fifo_rd_en <= 1'b0;
            done               <= 1'b0;
            break_req          <= 1'b0;
        end else begin
            state              <= state_d;
            opcode_q           <= opcode_d;
            tx_rem             <= tx_rem_d;
            rx_rem             <= rx_rem_d;
            ack_mode           <= ack_mode_d;
            echo_kind          <= echo_kind_d;
            status_q           <= status_d;
`ifdef UPDI_ECHO_CHECK_EN
            last_tx            <= last_tx_d;
`endif
            cmd_ready          <= cmd_ready_d;
            pl_ready           <= pl_ready_d;
            rx_data            <= rx_data_d;
            rx_wr_en           <= rx_wr_en_d;
            uart_tx_fifo_data  <= tx_data_d;
            uart_tx_fifo_wr_en <= tx_wr_en_d;
            uart_rx_fifo_rd_en <= rd_en_d;
            done               <= done_d;
            break_req          <= break_d;
        end
    end

    assign status = status_q;

endmodule

// File: tb/tb_updi_txn_engine.sv
// Directed bench for updi_txn_engine with queue-based FIFO and payload models.
module tb_updi_txn_engine;

    localparam int unsigned T = 100;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_opcode;
    logic [7:0] cmd_tx_len;
    logic [7:0] cmd_rx_len;
    logic       cmd_ack_mode;
    logic [7:0] pl_data;
    logic       pl_valid;
    logic       pl_ready;
    logic [7:0] rx_data;
    logic       rx_wr_en;
    logic       rx_full;
    logic [7:0] uart_tx_fifo_data;
    logic       uart_tx_fifo_wr_en;
    logic       uart_tx_fifo_full;
    logic [7:0] uart_rx_fifo_data;
    logic       uart_rx_fifo_rd_en;
    logic       uart_rx_fifo_empty;
    logic       done;
    logic [1:0] status;
    logic       break_req;

    updi_txn_engine #(
        .LEN_W        (8),
        .TIMEOUT_CLKS (T),
        .SYNC_BYTE    (8'h55),
        .ACK_BYTE     (8'h40),
        .ECHO_DISCARD (1'b1)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .cmd_valid          (cmd_valid),
        .cmd_ready          (cmd_ready),
        .cmd_opcode         (cmd_opcode),
        .cmd_tx_len         (cmd_tx_len),
        .cmd_rx_len         (cmd_rx_len),
        .cmd_ack_mode       (cmd_ack_mode),
        .pl_data            (pl_data),
        .pl_valid           (pl_valid),
        .pl_ready           (pl_ready),
        .rx_data            (rx_data),
        .rx_wr_en           (rx_wr_en),
        .rx_full            (rx_full),
        .uart_tx_fifo_data  (uart_tx_fifo_data),
        .uart_tx_fifo_wr_en (uart_tx_fifo_wr_en),
        .uart_tx_fifo_full  (uart_tx_fifo_full),
        .uart_rx_fifo_data  (uart_rx_fifo_data),
        .uart_rx_fifo_rd_en (uart_rx_fifo_rd_en),
        .uart_rx_fifo_empty (uart_rx_fifo_empty),
        .done               (done),
        .status             (status),
        .break_req          (break_req)
    );

    always #5 clk = ~clk;

    logic [7:0] rx_q[$];
    logic [7:0] pl_q[$];
    logic [7:0] tx_log[$];
    logic [7:0] resp_log[$];
    int         cyc = 0;
    int         done_cnt = 0;
    int         pl_ready_cnt = 0;
    int         last_pop_cyc = 0;
    int         done_cyc = 0;
    logic [1:0] done_status = 2'b00;
    logic       done_break = 1'b0;
    int         errors = 0;
    int         checks = 0;

    // FIFO / stream models: observe registered DUT strobes and refresh FIFO views mid-cycle.
    always @(negedge clk) begin
        logic [7:0] tmp;
        cyc++;
        if (rst) begin
            if (uart_rx_fifo_rd_en) begin
                last_pop_cyc = cyc;
                if (rx_q.size() > 0) tmp = rx_q.pop_front();
            end
            if (uart_tx_fifo_wr_en) tx_log.push_back(uart_tx_fifo_data);
            if (pl_ready) begin
                pl_ready_cnt++;
                if (pl_q.size() > 0) tmp = pl_q.pop_front();
            end
            if (rx_wr_en) resp_log.push_back(rx_data);
            if (done) begin
                done_cnt++;
                done_cyc    = cyc;
                done_status = status;
                done_break  = break_req;
            end
        end
        uart_rx_fifo_empty = (rx_q.size() == 0);
        uart_rx_fifo_data  = (rx_q.size() == 0) ? 8'h00 : rx_q[0];
        pl_valid           = (pl_q.size() != 0);
        pl_data            = (pl_q.size() == 0) ? 8'h00 : pl_q[0];
    end

    function automatic logic [7:0] q_at(input logic [7:0] q[$], input int i);
        return (i < q.size()) ? q[i] : 8'hxx;
    endfunction

    task automatic clear_logs();
        rx_q.delete();
        pl_q.delete();
        tx_log.delete();
        resp_log.delete();
        pl_ready_cnt = 0;
    endtask

    task automatic send_cmd(input logic [7:0] opc, input logic [7:0] txl,
                            input logic [7:0] rxl, input logic ack);
        int n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        cmd_opcode   = opc;
        cmd_tx_len   = txl;
        cmd_rx_len   = rxl;
        cmd_ack_mode = ack;
        cmd_valid    = 1'b1;
        @(negedge clk);
        cmd_valid    = 1'b0;
    endtask

    task automatic wait_done(input int start_cnt, input int budget, input string name);
        int n = 0;
        while (done_cnt == start_cnt && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (done_cnt == start_cnt) begin
            checks++;
            errors++;
            $display("FAIL %s_done_wait: no done within %0d cycles", name, budget);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_cmd_ready: got %b expected 1", cmd_ready);
        end
        checks++;
        if ({done, break_req, status, pl_ready, rx_wr_en, uart_tx_fifo_wr_en, uart_rx_fifo_rd_en} !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 00000000",
                     {done, break_req, status, pl_ready, rx_wr_en, uart_tx_fifo_wr_en, uart_rx_fifo_rd_en});
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: got ready=%b done=%b expected ready=1 done=0", cmd_ready, done);
        end
    endtask

    task automatic test_read();
        int d0;
        clear_logs();
        rx_q = '{8'h55, 8'h80, 8'h30};
        d0 = done_cnt;
        send_cmd(8'h80, 8'd0, 8'd1, 1'b0);
        wait_done(d0, 500, "read");
        repeat (5) @(negedge clk);
        checks++;
        if (tx_log.size() !== 2 || q_at(tx_log, 0) !== 8'h55 || q_at(tx_log, 1) !== 8'h80) begin
            errors++;
            $display("FAIL read_tx: got n=%0d %02h %02h expected n=2 55 80",
                     tx_log.size(), q_at(tx_log, 0), q_at(tx_log, 1));
        end
        checks++;
        if (resp_log.size() !== 1 || q_at(resp_log, 0) !== 8'h30) begin
            errors++;
            $display("FAIL read_resp: got n=%0d %02h expected n=1 30", resp_log.size(), q_at(resp_log, 0));
        end
        checks++;
        if (done_status !== 2'd0 || done_break !== 1'b0) begin
            errors++;
            $display("FAIL read_status: got %0d brk=%b expected 0 brk=0", done_status, done_break);
        end
        checks++;
        if (done_cnt - d0 !== 1) begin
            errors++;
            $display("FAIL read_done_count: got %0d expected 1", done_cnt - d0);
        end
        checks++;
        if (status !== 2'd0 || cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL read_idle_after: got status=%0d ready=%b expected 0 1", status, cmd_ready);
        end
    endtask

    task automatic test_write_ack();
        int d0;
        clear_logs();
        pl_q = '{8'h11, 8'h22};
        rx_q = '{8'h55, 8'h64, 8'h11, 8'h40, 8'h22, 8'h40};
        uart_tx_fifo_full = 1'b1;
        d0 = done_cnt;
        send_cmd(8'h64, 8'd2, 8'd0, 1'b1);
        repeat (300) @(negedge clk);
        checks++;
        if (tx_log.size() !== 0 || done_cnt !== d0) begin
            errors++;
            $display("FAIL write_tx_stall: got n=%0d dones=%0d expected n=0 dones=0",
                     tx_log.size(), done_cnt - d0);
        end
        uart_tx_fifo_full = 1'b0;
        wait_done(d0, 500, "write");
        repeat (3) @(negedge clk);
        checks++;
        if (tx_log.size() !== 4 || q_at(tx_log, 0) !== 8'h55 || q_at(tx_log, 1) !== 8'h64
            || q_at(tx_log, 2) !== 8'h11 || q_at(tx_log, 3) !== 8'h22) begin
            errors++;
            $display("FAIL write_tx: got n=%0d %02h %02h %02h %02h expected n=4 55 64 11 22",
                     tx_log.size(), q_at(tx_log, 0), q_at(tx_log, 1), q_at(tx_log, 2), q_at(tx_log, 3));
        end
        checks++;
        if (done_status !== 2'd0 || done_break !== 1'b0) begin
            errors++;
            $display("FAIL write_status: got %0d brk=%b expected 0 brk=0", done_status, done_break);
        end
        checks++;
        if (pl_ready_cnt !== 2) begin
            errors++;
            $display("FAIL write_pl_ready: got %0d expected 2", pl_ready_cnt);
        end
        checks++;
        if (resp_log.size() !== 0 || rx_q.size() !== 0) begin
            errors++;
            $display("FAIL write_rx_drain: got resp=%0d rxq=%0d expected 0 0", resp_log.size(), rx_q.size());
        end
    endtask

    task automatic test_nack();
        int d0;
        clear_logs();
        pl_q = '{8'h11, 8'h22};
        rx_q = '{8'h55, 8'h64, 8'h11, 8'h00};
        d0 = done_cnt;
        send_cmd(8'h64, 8'd2, 8'd0, 1'b1);
        wait_done(d0, 500, "nack");
        repeat (10) @(negedge clk);
        checks++;
        if (done_status !== 2'd2 || done_break !== 1'b1) begin
            errors++;
            $display("FAIL nack_status: got %0d brk=%b expected 2 brk=1", done_status, done_break);
        end
        checks++;
        if (tx_log.size() !== 3 || q_at(tx_log, 2) !== 8'h11) begin
            errors++;
            $display("FAIL nack_tx: got n=%0d last=%02h expected n=3 last=11", tx_log.size(), q_at(tx_log, 2));
        end
        checks++;
        if (pl_ready_cnt !== 1) begin
            errors++;
            $display("FAIL nack_pl_ready: got %0d expected 1", pl_ready_cnt);
        end
        checks++;
        if (status !== 2'd2) begin
            errors++;
            $display("FAIL nack_status_hold: got %0d expected 2", status);
        end
        pl_q.delete();
    endtask

    task automatic test_timeout();
        int d0;
        clear_logs();
        rx_q = '{8'h55, 8'h24, 8'hAA};
        d0 = done_cnt;
        send_cmd(8'h24, 8'd0, 8'd2, 1'b0);
        wait_done(d0, 1000, "timeout");
        repeat (3) @(negedge clk);
        checks++;
        if (done_status !== 2'd1 || done_break !== 1'b1) begin
            errors++;
            $display("FAIL timeout_status: got %0d brk=%b expected 1 brk=1", done_status, done_break);
        end
        checks++;
        if (done_cyc - last_pop_cyc !== int'(T)) begin
            errors++;
            $display("FAIL timeout_latency: got %0d expected %0d", done_cyc - last_pop_cyc, T);
        end
        checks++;
        if (resp_log.size() !== 1 || q_at(resp_log, 0) !== 8'hAA) begin
            errors++;
            $display("FAIL timeout_resp: got n=%0d %02h expected n=1 AA", resp_log.size(), q_at(resp_log, 0));
        end
    endtask

    task automatic test_rx_stall();
        int d0;
        clear_logs();
        rx_q = '{8'h55, 8'h24, 8'hA1, 8'hB2};
        rx_full = 1'b1;
        d0 = done_cnt;
        send_cmd(8'h24, 8'd0, 8'd2, 1'b0);
        repeat (500) @(negedge clk);
        checks++;
        if (done_cnt !== d0 || resp_log.size() !== 0) begin
            errors++;
            $display("FAIL stall_hold: got dones=%0d resp=%0d expected 0 0", done_cnt - d0, resp_log.size());
        end
        rx_full = 1'b0;
        wait_done(d0, 500, "stall");
        repeat (3) @(negedge clk);
        checks++;
        if (resp_log.size() !== 2 || q_at(resp_log, 0) !== 8'hA1 || q_at(resp_log, 1) !== 8'hB2) begin
            errors++;
            $display("FAIL stall_resp: got n=%0d %02h %02h expected n=2 A1 B2",
                     resp_log.size(), q_at(resp_log, 0), q_at(resp_log, 1));
        end
        checks++;
        if (done_status !== 2'd0 || done_break !== 1'b0) begin
            errors++;
            $display("FAIL stall_status: got %0d brk=%b expected 0 brk=0", done_status, done_break);
        end
    endtask

    task automatic test_echo();
        int d0;
        clear_logs();
        d0 = done_cnt;
`ifdef UPDI_ECHO_CHECK_EN
        rx_q = '{8'h54};
        send_cmd(8'h80, 8'd0, 8'd1, 1'b0);
        wait_done(d0, 500, "echo");
        repeat (3) @(negedge clk);
        checks++;
        if (done_status !== 2'd3 || done_break !== 1'b1) begin
            errors++;
            $display("FAIL echo_status: got %0d brk=%b expected 3 brk=1", done_status, done_break);
        end
        checks++;
        if (tx_log.size() !== 1) begin
            errors++;
            $display("FAIL echo_tx: got n=%0d expected 1", tx_log.size());
        end
`else
        rx_q = '{8'h54, 8'h80, 8'h30};
        send_cmd(8'h80, 8'd0, 8'd1, 1'b0);
        wait_done(d0, 500, "echo");
        repeat (3) @(negedge clk);
        checks++;
        if (done_status !== 2'd0 || done_break !== 1'b0) begin
            errors++;
            $display("FAIL echo_status: got %0d brk=%b expected 0 brk=0", done_status, done_break);
        end
        checks++;
        if (resp_log.size() !== 1 || q_at(resp_log, 0) !== 8'h30) begin
            errors++;
            $display("FAIL echo_resp: got n=%0d %02h expected n=1 30", resp_log.size(), q_at(resp_log, 0));
        end
`endif
    endtask

    task automatic test_reset_mid();
        int d0;
        int n = 0;
        clear_logs();
        pl_q = '{8'h11};
        rx_q = '{8'h55, 8'h64, 8'h11, 8'h40};
        d0 = done_cnt;
        send_cmd(8'h64, 8'd3, 8'd0, 1'b1);
        while ((tx_log.size() < 3 || rx_q.size() != 0) && n < 500) begin
            @(negedge clk);
            n++;
        end
        repeat (10) @(negedge clk);
        checks++;
        if (tx_log.size() !== 3 || done_cnt !== d0) begin
            errors++;
            $display("FAIL mid_progress: got tx=%0d dones=%0d expected 3 0", tx_log.size(), done_cnt - d0);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (cmd_ready !== 1'b1 ||
            {done, break_req, status, pl_ready, rx_wr_en, uart_tx_fifo_wr_en, uart_rx_fifo_rd_en} !== 8'h00) begin
            errors++;
            $display("FAIL mid_reset_outputs: got ready=%b outs=%b expected ready=1 outs=00000000", cmd_ready,
                     {done, break_req, status, pl_ready, rx_wr_en, uart_tx_fifo_wr_en, uart_rx_fifo_rd_en});
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if (done_cnt !== d0) begin
            errors++;
            $display("FAIL mid_no_done: got %0d extra dones expected 0", done_cnt - d0);
        end
        clear_logs();
        rx_q = '{8'h55, 8'h80, 8'h5A};
        send_cmd(8'h80, 8'd0, 8'd1, 1'b0);
        wait_done(d0, 500, "mid_next");
        repeat (3) @(negedge clk);
        checks++;
        if (done_status !== 2'd0 || resp_log.size() !== 1 || q_at(resp_log, 0) !== 8'h5A) begin
            errors++;
            $display("FAIL mid_next_cmd: got st=%0d n=%0d %02h expected st=0 n=1 5A",
                     done_status, resp_log.size(), q_at(resp_log, 0));
        end
        checks++;
        if (tx_log.size() !== 2 || q_at(tx_log, 1) !== 8'h80) begin
            errors++;
            $display("FAIL mid_next_tx: got n=%0d %02h expected n=2 80", tx_log.size(), q_at(tx_log, 1));
        end
    endtask

    initial begin
        rst               = 1'b0;
        cmd_valid         = 1'b0;
        cmd_opcode        = 8'h00;
        cmd_tx_len        = 8'd0;
        cmd_rx_len        = 8'd0;
        cmd_ack_mode      = 1'b0;
        rx_full           = 1'b0;
        uart_tx_fifo_full = 1'b0;
        uart_rx_fifo_empty = 1'b1;
        uart_rx_fifo_data = 8'h00;
        pl_valid          = 1'b0;
        pl_data           = 8'h00;

        test_reset();
        test_read();
        test_write_ack();
        test_nack();
        test_timeout();
        test_rx_stall();
        test_echo();
        test_reset_mid();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
